as5600_i2c_target: RTL and testbench

- I2C target (responder) that emulates the AS5600 magnetic encoder's read-only angle registers on the `scl`/`sda` bus.
- Used in simulation and hardware-in-the-loop builds in place of the physical sensor, so the on-chip I2C angle reader and the angle-to-PWM loop can be exercised against a known, programmable angle.
- Oversamples the bus on the system clock, decodes START/STOP, address and register-pointer writes, and returns the 12-bit angle from a coherent snapshot.

---
 rtl/as5600_i2c_target.sv | 227 ++++++++++++++++++++++
 tb/tb_as5600_i2c_target.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 read-only angle registers (0x0C..0x0F).
// Optional define AS5600_STATUS_EN: serves status register 0x0B and NACKs the address when no magnet is present.
module as5600_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h36
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] angle_in,
    input  logic        magnet_ok,
    input  logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        rd_strobe
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s2_q, scl_h_q;
    logic        sda_s1_q, sda_s2_q, sda_h_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [11:0] snap_q, snap_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        mack_q, mack_d;
    logic [1:0]  dly_q, dly_d;
    logic        pend_q, pend_d;
    logic        oe_q, oe_d;
    logic        strobe_q, strobe_d;

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        is_hi_reg, do_load, sched, sched_oe, addr_ok;
    logic [7:0]  tx_byte;

`ifdef AS5600_STATUS_EN
    assign addr_ok = magnet_ok;
`else
    logic unused_magnet_ok;
    assign unused_magnet_ok = magnet_ok;
    assign addr_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    // High bytes are served straight from angle_in because that value is captured into snap on the same edge.
    always_comb begin
        is_hi_reg = (ptr_q == 8'h0C) || (ptr_q == 8'h0E);
        case (ptr_q)
            8'h0C, 8'h0E: tx_byte = {4'b0000, angle_in[11:8]};
            8'h0D, 8'h0F: tx_byte = snap_q[7:0];
`ifdef AS5600_STATUS_EN
            8'h0B:        tx_byte = {2'b00, magnet_ok, 5'b00000};
`endif
            default:      tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        snap_d    = snap_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        mack_d    = mack_q;
        dly_d     = dly_q;
        pend_d    = pend_q;
        oe_d      = oe_q;
        strobe_d  = 1'b0;
        do_load   = 1'b0;
        sched     = 1'b0;
        sched_oe  = 1'b0;

        if (dly_q != 2'd0) begin
            dly_d = dly_q - 2'd1;
            if (dly_q == 2'd1) oe_d = pend_q;
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            dly_d     = 2'd0;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            dly_d   = 2'd0;
        end else begin
            case (state_q)
                ADDR, REG: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == REG) begin
                            ptr_d    = shift_q;
                            state_d  = REG_ACK;
                            sched    = 1'b1;
                            sched_oe = 1'b1;
                        end else if (shift_q[7:1] == DEV_ADDR && addr_ok) begin
                            state_d  = ADDR_ACK;
                            rw_d     = shift_q[0];
                            busy_d   = 1'b1;
                            sched    = 1'b1;
                            sched_oe = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    bit_cnt_d = 4'd0;
                    if (rw_q) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = REG;
                        sched   = 1'b1;
                    end
                end
                REG_ACK: if (scl_fall) begin
                    state_d = WAIT_STOP;
                    sched   = 1'b1;
                end
                TX: if (scl_fall) begin
                    sched = 1'b1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = TX_ACK;
                    end else begin
                        sched_oe  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                TX_ACK: begin
                    if (scl_rise) mack_d = ~sda_s2_q;
                    else if (scl_fall) begin
                        if (mack_q) do_load = 1'b1;
                        else        state_d = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end

        if (do_load) begin
            state_d   = TX;
            shift_d   = {tx_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            ptr_d     = ptr_q + 8'd1;
            sched     = 1'b1;
            sched_oe  = ~tx_byte[7];
            if (is_hi_reg) begin
                snap_d   = angle_in;
                strobe_d = 1'b1;
            end
        end

        // SDA follows the detected SCL fall by three clocks to give the master hold time.
        if (sched) begin
            dly_d  = 2'd3;
            pend_d = sched_oe;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            snap_q    <= 12'h000;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            mack_q    <= 1'b0;
            dly_q     <= 2'd0;
            pend_q    <= 1'b0;
            oe_q      <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            snap_q    <= snap_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            mack_q    <= mack_d;
            dly_q     <= dly_d;
            pend_q    <= pend_d;
            oe_q      <= oe_d;
            strobe_q  <= strobe_d;
        end
    end

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign rd_strobe = strobe_q;

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for as5600_i2c_target: bit-banged I2C master, register-map model and a per-cycle bus checker.
module tb_as5600_i2c_target;
    localparam int         H   = 10;
    localparam logic [6:0] DEV = 7'h36;

    logic        clock;
    logic        reset_n;
    logic [11:0] angle_in;
    logic        magnet_ok;
    logic        scl;
    logic        m_low;
    wire         sda;
    logic        busy;
    logic        rd_strobe;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          dut_strobes  = 0;
    int          exp_strobes  = 0;
    logic        exp_valid    = 1'b0;
    logic        exp_sda      = 1'b1;
    logic        exp_busy     = 1'b0;
    logic [7:0]  m_ptr;
    logic [11:0] m_snap;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    as5600_i2c_target #(.DEV_ADDR(DEV)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .angle_in  (angle_in),
        .magnet_ok (magnet_ok),
        .scl       (scl),
        .sda       (sda),
        .busy      (busy),
        .rd_strobe (rd_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus checker: while SCL is high and settled, the line and busy must match the model.
    always @(negedge clock) begin
        if (rd_strobe) dut_strobes++;
        if (exp_valid) begin
            check("bus_sda", 32'(sda), 32'(exp_sda));
            check("busy", 32'(busy), 32'(exp_busy));
        end
    end

    function automatic logic gate_ok();
`ifdef AS5600_STATUS_EN
        return magnet_ok;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] model_reg(input logic [7:0] a);
        if (a == 8'h0C || a == 8'h0E) return {4'h0, m_snap[11:8]};
        if (a == 8'h0D || a == 8'h0F) return m_snap[7:0];
`ifdef AS5600_STATUS_EN
        if (a == 8'h0B) return {2'b00, magnet_ok, 5'b00000};
`endif
        return 8'h00;
    endfunction

    task automatic model_next(output logic [7:0] e);
        if (m_ptr == 8'h0C || m_ptr == 8'h0E) begin
            m_snap = angle_in;
            exp_strobes++;
        end
        e     = model_reg(m_ptr);
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Entered with SCL low just after a fall; leaves SCL low just after the next fall.
    task automatic xfer_bit(input logic mbit, input logic ebit, input logic ebusy, output logic rbit);
        tick(4);
        m_low = ~mbit;
        tick(6);
        scl = 1'b1;
        tick(4);
        exp_sda   = ebit;
        exp_busy  = ebusy;
        exp_valid = 1'b1;
        tick(4);
        rbit      = sda;
        exp_valid = 1'b0;
        tick(2);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        tick(H);
        m_low = 1'b1;
        tick(H);
        scl = 1'b0;
    endtask

    task automatic rstart_cond();
        tick(4);
        m_low = 1'b0;
        tick(6);
        scl = 1'b1;
        tick(5);
        m_low = 1'b1;
        tick(5);
        scl = 1'b0;
    endtask

    task automatic stop_cond(input logic chk_drop);
        tick(7);
        check("sda_released", 32'(sda), 32'd1);
        m_low = 1'b1;
        tick(3);
        scl = 1'b1;
        tick(5);
        m_low = 1'b0;
        if (chk_drop) begin
            tick(2);
            check("busy_pre_stop", 32'(busy), 32'd1);
            tick(1);
            check("busy_post_stop", 32'(busy), 32'd0);
            tick(H - 3);
        end else begin
            tick(H);
        end
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, output logic matched, output logic ackbit);
        logic [7:0] b;
        logic       r;
        b       = {a, rw};
        matched = (a == DEV) && gate_ok();
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], b[i], 1'b0, r);
        xfer_bit(1'b1, ~matched, matched, ackbit);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_nack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], b[i], 1'b1, r);
        xfer_bit(1'b1, exp_nack, 1'b1, r);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] got);
        logic [7:0] e;
        logic       r;
        model_next(e);
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, e[i], 1'b1, got[i]);
        xfer_bit(~mack, ~mack, 1'b1, r);
    endtask

    task automatic write_ptr(input logic [7:0] p);
        logic m, a;
        start_cond();
        addr_phase(DEV, 1'b0, m, a);
        write_byte(p, 1'b0);
        m_ptr = p;
    endtask

    task automatic open_read();
        logic m, a;
        addr_phase(DEV, 1'b1, m, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m, a, r;
        logic [7:0] g0, g1, g2;
        logic [7:0] gq [12];
        int         s0;

        reset_n   = 1'b0;
        scl       = 1'b1;
        m_low     = 1'b0;
        angle_in  = 12'hA5C;
        magnet_ok = 1'b1;
        m_ptr     = 8'h00;
        m_snap    = 12'h000;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(rd_strobe), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        reset_n = 1'b1;
        tick(5);

        // Pointer write, repeated start, two-byte angle read.
        s0 = dut_strobes;
        write_ptr(8'h0C);
        rstart_cond();
        open_read();
        read_byte(1'b1, g0);
        read_byte(1'b0, g1);
        stop_cond(1'b1);
        check("t1_hi", 32'(g0), 32'h0A);
        check("t1_lo", 32'(g1), 32'h5C);
        check("t1_one_strobe", 32'(dut_strobes - s0), 32'd1);
        check("t1_strobes", 32'(dut_strobes), 32'(exp_strobes));

        // Angle changes between the bytes; the low byte comes from the snapshot.
        write_ptr(8'h0C);
        rstart_cond();
        open_read();
        read_byte(1'b1, g0);
        angle_in = 12'h123;
        read_byte(1'b0, g1);
        stop_cond(1'b0);
        check("t2_hi", 32'(g0), 32'h0A);
        check("t2_lo_held", 32'(g1), 32'h5C);

        // Foreign address: no ACK, line never pulled, busy stays low.
        s0 = dut_strobes;
        start_cond();
        addr_phase(7'h37, 1'b1, m, a);
        check("t3_nack", 32'(a), 32'd1);
        for (int i = 0; i < 9; i++) xfer_bit(1'b1, 1'b1, 1'b0, r);
        stop_cond(1'b0);
        check("t3_no_strobe", 32'(dut_strobes - s0), 32'd0);

        // Pointer wrap from 0xFF, then confirm where it ended up.
        write_ptr(8'hFF);
        rstart_cond();
        open_read();
        read_byte(1'b1, g0);
        read_byte(1'b1, g1);
        read_byte(1'b0, g2);
        stop_cond(1'b0);
        check("t4_b0", 32'(g0), 32'h00);
        check("t4_b1", 32'(g1), 32'h00);
        check("t4_b2", 32'(g2), 32'h00);
        check("t4_model_ptr", 32'(m_ptr), 32'h02);
        start_cond();
        open_read();
        for (int i = 0; i < 12; i++) read_byte(i != 11, gq[i]);
        stop_cond(1'b0);
        check("t4_ptr_hi", 32'(gq[10]), 32'h01);
        check("t4_ptr_lo", 32'(gq[11]), 32'h23);

        // Extra write data is refused; pointer is left alone.
        write_ptr(8'h0C);
        write_byte(8'h55, 1'b1);
        stop_cond(1'b0);
        start_cond();
        open_read();
        read_byte(1'b0, g0);
        stop_cond(1'b0);
        check("t5_hi_after_nack", 32'(g0), 32'h01);

        // Status register and magnet-absent behaviour.
        write_ptr(8'h0B);
        rstart_cond();
        open_read();
        read_byte(1'b0, g0);
        stop_cond(1'b0);
`ifdef AS5600_STATUS_EN
        check("t6_status", 32'(g0), 32'h20);
`else
        check("t6_status", 32'(g0), 32'h00);
`endif
        magnet_ok = 1'b0;
        start_cond();
        addr_phase(DEV, 1'b1, m, a);
`ifdef AS5600_STATUS_EN
        check("t6_no_magnet_ack", 32'(a), 32'd1);
`else
        check("t6_no_magnet_ack", 32'(a), 32'd0);
`endif
        if (m) read_byte(1'b0, g0);
        stop_cond(1'b0);
        magnet_ok = 1'b1;

        // Reset while the address ACK is on the line.
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            g1 = {DEV, 1'b0};
            xfer_bit(g1[i], g1[i], 1'b0, r);
        end
        tick(4);
        m_low = 1'b0;
        tick(4);
        check("t7_ack_driven", 32'(sda), 32'd0);
        reset_n = 1'b0;
        #1;
        check("t7_rst_release", 32'(sda), 32'd1);
        check("t7_rst_busy", 32'(busy), 32'd0);
        tick(2);
        reset_n = 1'b1;
        m_ptr   = 8'h00;
        m_snap  = 12'h000;
        tick(2);
        scl = 1'b1;
        tick(H);
        write_ptr(8'h0D);
        rstart_cond();
        open_read();
        read_byte(1'b0, g0);
        stop_cond(1'b0);
        check("t7_snap_cleared", 32'(g0), 32'h00);
        check("final_strobes", 32'(dut_strobes), 32'(exp_strobes));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
